// File: rtl/tx_8b10b_pkg.sv
// Shared 8b10b constants: fill words, sub-block code tables, A7 selection sets
// and the transmitter state encoding.
package tx8b10b_pkg;

    localparam logic [9:0] FILL_WORD_RD0_DEFAULT = 10'b0011111010;
    localparam logic [9:0] FILL_WORD_RD1_DEFAULT = 10'b1100000101;

    // {non-neutral, abcdei} in the RD- form; the RD+ form of a non-neutral entry is its complement
    localparam logic [6:0] ENC_5B6B [32] = '{
        7'b1_100111, 7'b1_011101, 7'b1_101101, 7'b0_110001,
        7'b1_110101, 7'b0_101001, 7'b0_011001, 7'b0_111000,
        7'b1_111001, 7'b0_100101, 7'b0_010101, 7'b0_110100,
        7'b0_001101, 7'b0_101100, 7'b0_011100, 7'b1_010111,
        7'b1_011011, 7'b0_100011, 7'b0_010011, 7'b0_110010,
        7'b0_001011, 7'b0_101010, 7'b0_011010, 7'b1_111010,
        7'b1_110011, 7'b0_100110, 7'b0_010110, 7'b1_110110,
        7'b0_001110, 7'b1_101110, 7'b1_011110, 7'b1_101011
    };

    // {non-neutral, fghj} in the RD- form; entry 7 is the primary P7 code
    localparam logic [4:0] ENC_3B4B [8] = '{
        5'b1_1011, 5'b0_1001, 5'b0_0101, 5'b0_1100,
        5'b1_1101, 5'b0_1010, 5'b0_0110, 5'b1_1110
    };

    // Bit x set => D.x.7 uses A7 at that running disparity (avoids a run of five)
    localparam logic [31:0] A7_SET_RDM = 32'h0016_0000;  // x = 17, 18, 20
    localparam logic [31:0] A7_SET_RDP = 32'h0000_6800;  // x = 11, 13, 14

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COMMA = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/tx_8b10b_if.sv
// Byte-side and line-side signals of the serial 8b10b transmitter.
interface tx_8b10b_if;
    logic       txEnable;
    logic       writeStrobe;
    logic [7:0] dataIn;
    logic       tx;
    logic       busy;
    logic       symbolStart;
    logic       halfFull;
    logic       full;

    modport master (
        output txEnable, writeStrobe, dataIn,
        input  tx, busy, symbolStart, halfFull, full
    );

    modport slave (
        input  txEnable, writeStrobe, dataIn,
        output tx, busy, symbolStart, halfFull, full
    );
endinterface

// File: rtl/tx_8b10b_enc.sv
// Combinational 8b10b data encoder with running-disparity in/out.
module enc_8b10b
    import tx8b10b_pkg::*;
(
    input  logic [7:0] data,
    input  logic       rdIn,
    output logic [9:0] code,
    output logic       rdOut
);
    logic [4:0] x;
    logic [2:0] y;
    logic [6:0] entry6;
    logic [4:0] entry4;
    logic [5:0] code6;
    logic [3:0] base4;
    logic [3:0] code4;
    logic       rdMid;
    logic       useA7;

    assign x = data[4:0];
    assign y = data[7:5];

    always_comb begin
        entry6 = ENC_5B6B[x];
        // D.7 is neutral but still has distinct RD-/RD+ forms
        code6  = (rdIn && (entry6[6] || x == 5'd7)) ? ~entry6[5:0] : entry6[5:0];
        rdMid  = rdIn ^ entry6[6];

        entry4 = ENC_3B4B[y];
        useA7  = (y == 3'd7) && (rdMid ? A7_SET_RDP[x] : A7_SET_RDM[x]);
        base4  = useA7 ? 4'b0111 : entry4[3:0];
        code4  = (rdMid && (entry4[4] || y == 3'd3)) ? ~base4 : base4;
        rdOut  = rdMid ^ entry4[4];

        code   = {code6, code4};
    end
endmodule

// File: rtl/tx_8b10b_fifo.sv
// First-word-fall-through byte queue; LOG2_DEPTH=0 collapses it to one holding register.
module Fifo #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] wrData,
    input  logic             rdEn,
    output logic [WIDTH-1:0] rdData,
    output logic             empty,
    output logic             full,
    output logic             halfFull
);
    generate
        if (LOG2_DEPTH == 0) begin : gHold
            logic             validReg;
            logic [WIDTH-1:0] dataReg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    validReg <= 1'b0;
                    dataReg  <= '0;
                end else if (wrEn && !validReg) begin
                    validReg <= 1'b1;
                    dataReg  <= wrData;
                end else if (rdEn && validReg) begin
                    validReg <= 1'b0;
                end
            end

            assign rdData   = dataReg;
            assign empty    = !validReg;
            assign full     = validReg;
            assign halfFull = validReg;
        end else begin : gQueue
            localparam int DEPTH = 1 << LOG2_DEPTH;
            localparam int CW    = LOG2_DEPTH + 1;

            logic [WIDTH-1:0]      mem [DEPTH];
            logic [LOG2_DEPTH-1:0] wrPtrReg;
            logic [LOG2_DEPTH-1:0] rdPtrReg;
            logic [LOG2_DEPTH-1:0] rdAddr;
            logic [CW-1:0]         countReg;
            logic [WIDTH-1:0]      headReg;
            logic                  doWrite;
            logic                  doRead;

            assign doWrite = wrEn && !countReg[LOG2_DEPTH];
            assign doRead  = rdEn && (countReg != '0);
            assign rdAddr  = doRead ? rdPtrReg + 1'b1 : rdPtrReg;

            always_ff @(posedge clk) begin
                if (doWrite) begin
                    mem[wrPtrReg] <= wrData;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wrPtrReg <= '0;
                    rdPtrReg <= '0;
                    countReg <= '0;
                    headReg  <= '0;
                end else begin
                    if (doWrite) begin
                        wrPtrReg <= wrPtrReg + 1'b1;
                    end
                    rdPtrReg <= rdAddr;
                    countReg <= countReg + CW'(doWrite) - CW'(doRead);
                    // A write landing on the next head slot bypasses the array read
                    headReg  <= (doWrite && wrPtrReg == rdAddr) ? wrData : mem[rdAddr];
                end
            end

            assign rdData   = headReg;
            assign empty    = (countReg == '0);
            assign full     = countReg[LOG2_DEPTH];
            assign halfFull = (countReg >= CW'(DEPTH / 2));
        end
    endgenerate
endmodule

// File: rtl/tx_8b10b.sv
// Serial 8b10b transmitter: queued bytes are encoded with running disparity and
// shifted out MSB ('a') first; comma fill words keep the far end aligned when idle.
module tx_8b10b
    import tx8b10b_pkg::*;
#(
    parameter logic [9:0] FILL_WORD_RD0  = FILL_WORD_RD0_DEFAULT,
    parameter logic [9:0] FILL_WORD_RD1  = FILL_WORD_RD1_DEFAULT,
    parameter bit         FILL_WORD_FLIP = 1'b1,
    parameter int         CLK_RATE       = 8,
    parameter int         LOG2_DEPTH     = 4
) (
    input  logic     clk,
    input  logic     rst,
    tx_8b10b_if.slave bus
);
    localparam int            CW     = $clog2(CLK_RATE);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_RATE - 1);

    state_t        stateReg, stateNext;
    logic [CW-1:0] clkCountReg, clkCountNext;
    logic [3:0]    bitCountReg, bitCountNext;
    logic [9:0]    shiftReg, shiftNext;
    logic          rdReg, rdNext;
    logic          symStartReg, symStartNext;

    logic          popReq;
    logic [7:0]    headData;
    logic          fifoEmpty;
    logic          fifoFull;
    logic          fifoHalf;
    logic [9:0]    encCode;
    logic          encRd;
    logic [9:0]    fillWord;
    logic          fillRd;

    Fifo #(
        .WIDTH      (8),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) uFifo (
        .clk      (clk),
        .rst      (rst),
        .wrEn     (bus.writeStrobe),
        .wrData   (bus.dataIn),
        .rdEn     (popReq),
        .rdData   (headData),
        .empty    (fifoEmpty),
        .full     (fifoFull),
        .halfFull (fifoHalf)
    );

    enc_8b10b uEnc (
        .data  (headData),
        .rdIn  (rdReg),
        .code  (encCode),
        .rdOut (encRd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg    <= IDLE;
            clkCountReg <= '0;
            bitCountReg <= '0;
            shiftReg    <= '0;
            rdReg       <= 1'b0;
            symStartReg <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            clkCountReg <= clkCountNext;
            bitCountReg <= bitCountNext;
            shiftReg    <= shiftNext;
            rdReg       <= rdNext;
            symStartReg <= symStartNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        clkCountNext = clkCountReg;
        bitCountNext = bitCountReg;
        shiftNext    = shiftReg;
        rdNext       = rdReg;
        symStartNext = 1'b0;
        popReq       = 1'b0;
        fillWord     = rdReg ? FILL_WORD_RD1 : FILL_WORD_RD0;
        fillRd       = FILL_WORD_FLIP ? ~rdReg : rdReg;

        case (stateReg)
            IDLE: begin
                rdNext       = 1'b0;
                shiftNext    = '0;
                bitCountNext = '0;
                clkCountNext = '0;
                if (bus.txEnable) begin
                    // RD is -1 here, so the opening comma is always the RD0 word
                    stateNext    = COMMA;
                    shiftNext    = FILL_WORD_RD0;
                    rdNext       = FILL_WORD_FLIP;
                    clkCountNext = RELOAD;
                    symStartNext = 1'b1;
                end
            end
            default: begin
                if (clkCountReg != '0) begin
                    clkCountNext = clkCountReg - 1'b1;
                end else if (bitCountReg != 4'd9) begin
                    bitCountNext = bitCountReg + 4'd1;
                    shiftNext    = {shiftReg[8:0], 1'b0};
                    clkCountNext = RELOAD;
                end else if (!bus.txEnable) begin
                    stateNext    = IDLE;
                    shiftNext    = '0;
                    rdNext       = 1'b0;
                    bitCountNext = '0;
                end else begin
                    stateNext    = RUN;
                    bitCountNext = '0;
                    clkCountNext = RELOAD;
                    symStartNext = 1'b1;
                    if (!fifoEmpty) begin
                        popReq    = 1'b1;
                        shiftNext = encCode;
                        rdNext    = encRd;
                    end else begin
                        shiftNext = fillWord;
                        rdNext    = fillRd;
                    end
                end
            end
        endcase
    end

    always_comb begin
        bus.tx          = shiftReg[9];
        bus.busy        = (stateReg != IDLE);
        bus.symbolStart = symStartReg;
        bus.halfFull    = fifoHalf;
        bus.full        = fifoFull;
    end
endmodule

// File: tb/tb_tx_8b10b.sv
// Directed and randomized checks of tx_8b10b against a disparity-counting 8b10b model.
module tb_tx_8b10b;
    localparam int         CLK_RATE = 8;
    localparam int         SYM      = 10 * CLK_RATE;
    localparam logic [9:0] FW0      = 10'b0011111010;
    localparam logic [9:0] FW1      = 10'b1100000101;

    logic clk;
    logic rst;
    tx_8b10b_if bus ();

    tx_8b10b #(
        .FILL_WORD_RD0  (FW0),
        .FILL_WORD_RD1  (FW1),
        .FILL_WORD_FLIP (1'b1),
        .CLK_RATE       (CLK_RATE),
        .LOG2_DEPTH     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Standard RD- sub-block codes (abcdei / fghj)
    logic [5:0] refSix  [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
    };
    logic [3:0] refFour [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
    };

    int         vectors     = 0;
    int         miscompares = 0;
    int         glitches    = 0;
    int         cycle       = 0;
    logic [9:0] rxQ [$];
    int         startQ [$];
    logic       modelRd;

    // Reference: pick the sub-block form from its ones count and the current RD
    function automatic logic [10:0] refEncode(input logic [7:0] b, input logic rdIn);
        int         x = int'(b[4:0]);
        int         y = int'(b[7:5]);
        logic       rd = rdIn;
        logic [5:0] six = refSix[x];
        logic [3:0] four;
        if (rd && ($countones(six) != 3 || six == 6'b111000)) six = ~six;
        if ($countones(six) > 3) rd = 1'b1;
        else if ($countones(six) < 3) rd = 1'b0;
        if (y == 7) begin
            if (rd ? (x inside {11, 13, 14}) : (x inside {17, 18, 20})) four = 4'b0111;
            else four = 4'b1110;
        end else begin
            four = refFour[y];
        end
        if (rd && ($countones(four) != 2 || four == 4'b1100)) four = ~four;
        if ($countones(four) > 2) rd = 1'b1;
        else if ($countones(four) < 2) rd = 1'b0;
        return {rd, six, four};
    endfunction

    // Line monitor: captures each symbol bit-by-bit and counts mid-bit transitions
    initial begin
        bit       capturing = 1'b0;
        int       clkIdx = 0;
        int       bitIdx = 0;
        logic [9:0] cur = '0;
        forever begin
            @(negedge clk);
            cycle++;
            if (rst) begin
                capturing = 1'b0;
            end else begin
                if (bus.symbolStart) begin
                    capturing = 1'b1;
                    clkIdx = 0;
                    bitIdx = 0;
                    cur = '0;
                    startQ.push_back(cycle);
                end
                if (capturing) begin
                    if (clkIdx == 0) cur[9-bitIdx] = bus.tx;
                    else if (bus.tx !== cur[9-bitIdx]) glitches++;
                    clkIdx++;
                    if (clkIdx == CLK_RATE) begin
                        clkIdx = 0;
                        bitIdx++;
                        if (bitIdx == 10) begin
                            rxQ.push_back(cur);
                            capturing = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        $display("chk %-22s observed %0h expected %0h", tag, obs, exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expectSym(input string tag, input logic [9:0] exp);
        logic [9:0] got;
        int         waited = 0;
        while (rxQ.size() == 0 && waited < 4 * SYM) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (rxQ.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed no symbol in %0d clocks expected %b", tag, 4 * SYM, exp);
        end else begin
            got = rxQ.pop_front();
            $display("sym %-22s observed %b expected %b", tag, got, exp);
            assert (got === exp) else begin
                miscompares++;
                $error("FAIL %s: observed %b expected %b", tag, got, exp);
            end
        end
    endtask

    task automatic expectFill(input string tag);
        expectSym(tag, modelRd ? FW1 : FW0);
        modelRd = ~modelRd;
    endtask

    task automatic expectByte(input string tag, input logic [7:0] b);
        logic [10:0] r;
        r = refEncode(b, modelRd);
        modelRd = r[10];
        expectSym(tag, r[9:0]);
    endtask

    task automatic waitSymStart(input string tag);
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.symbolStart !== 1'b1 && waited < 3 * SYM);
        if (bus.symbolStart !== 1'b1) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed no symbolStart expected one within %0d clocks", tag, 3 * SYM);
        end
    endtask

    task automatic waitIdle(input string tag);
        int waited = 0;
        while (bus.busy !== 1'b0 && waited < 4 * SYM) begin
            @(negedge clk);
            waited++;
        end
        check(tag, 32'(bus.busy), 32'd0);
    endtask

    task automatic setEnable(input logic en);
        @(posedge clk);
        #1 bus.txEnable = en;
    endtask

    task automatic writeByte(input logic [7:0] b);
        @(posedge clk);
        #1 bus.writeStrobe = 1'b1;
        bus.dataIn = b;
        @(posedge clk);
        #1 bus.writeStrobe = 1'b0;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1 rst = 1'b1;
        bus.txEnable = 1'b0;
        bus.writeStrobe = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rxQ.delete();
        startQ.delete();
        modelRd = 1'b0;
    endtask

    initial begin
        logic [7:0] bytes [16];
        int         n;
        int         cnt;
        rst = 1'b1;
        bus.txEnable = 1'b0;
        bus.writeStrobe = 1'b0;
        bus.dataIn = '0;
        modelRd = 1'b0;

        // Reset state
        doReset();
        @(negedge clk);
        check("rst_tx", 32'(bus.tx), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_symstart", 32'(bus.symbolStart), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_halffull", 32'(bus.halfFull), 32'd0);

        // Idle link: alternating comma words, 80 clocks apart
        setEnable(1'b1);
        expectSym("t1_fill0", FW0);
        expectSym("t1_fill1", FW1);
        expectSym("t1_fill2", FW0);
        expectSym("t1_fill3", FW1);
        check("t1_busy", 32'(bus.busy), 32'd1);
        for (int i = 1; i < 4; i++) check("t1_sym_spacing", 32'(startQ[i] - startQ[i-1]), 32'(SYM));
        setEnable(1'b0);
        waitIdle("t1_idle");

        // Queued D0.0 after the opening comma
        doReset();
        writeByte(8'h00);
        setEnable(1'b1);
        expectSym("t2_comma", 10'b0011111010);
        expectSym("t2_d0_0_rdp", 10'b0110001011);
        expectSym("t2_fill_rdp", 10'b1100000101);
        setEnable(1'b0);
        waitIdle("t2_idle");

        // Alternate D.x.7 at both disparities
        doReset();
        setEnable(1'b1);
        waitSymStart("t3_comma_start");
        writeByte(8'hEB);
        waitSymStart("t3_eb_start");
        writeByte(8'hF1);
        expectSym("t3_comma", FW0);
        expectSym("t3_d11_7_rdp", 10'b1101001000);
        expectSym("t3_d17_7_rdm", 10'b1000110111);
        expectSym("t3_fill_rdp", FW1);
        setEnable(1'b0);
        waitIdle("t3_idle");

        // Fill the queue, overflow by one, drain back-to-back
        doReset();
        for (int i = 1; i <= 17; i++) begin
            writeByte(8'(i));
            @(negedge clk);
            if (i == 7) check("t4_half_at7", 32'(bus.halfFull), 32'd0);
            if (i == 8) check("t4_half_at8", 32'(bus.halfFull), 32'd1);
            if (i == 15) check("t4_full_at15", 32'(bus.full), 32'd0);
            if (i >= 16) check("t4_full_at16plus", 32'(bus.full), 32'd1);
        end
        setEnable(1'b1);
        expectFill("t4_comma");
        for (int i = 1; i <= 16; i++) expectByte("t4_data", 8'(i));
        expectFill("t4_fill_after_drop");
        @(negedge clk);
        check("t4_full_drained", 32'(bus.full), 32'd0);
        setEnable(1'b0);
        waitIdle("t4_idle");

        // Disable during bit 3 of a data symbol: it finishes, then idle; queued byte survives
        doReset();
        writeByte(8'h55);
        writeByte(8'hA3);
        setEnable(1'b1);
        waitSymStart("t5_comma_start");
        waitSymStart("t5_data_start");
        repeat (26) @(posedge clk);
        #1 bus.txEnable = 1'b0;
        cnt = 25;
        do begin
            @(negedge clk);
            cnt++;
        end while (bus.busy !== 1'b0 && cnt < 300);
        check("t5_idle_clock", 32'(cnt), 32'(SYM));
        check("t5_idle_tx", 32'(bus.tx), 32'd0);
        expectFill("t5_comma");
        expectByte("t5_d21_2", 8'h55);
        modelRd = 1'b0;
        setEnable(1'b1);
        expectFill("t5_restart_comma");
        expectByte("t5_retained_byte", 8'hA3);
        setEnable(1'b0);
        waitIdle("t5_idle2");

        // Reset mid-symbol abandons the symbol and empties the queue
        doReset();
        for (int i = 0; i < 9; i++) writeByte(8'($urandom_range(0, 255)));
        @(negedge clk);
        check("t6_half_before", 32'(bus.halfFull), 32'd1);
        setEnable(1'b1);
        waitSymStart("t6_comma_start");
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_tx", 32'(bus.tx), 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        check("t6_rst_full", 32'(bus.full), 32'd0);
        check("t6_rst_halffull", 32'(bus.halfFull), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        rxQ.delete();
        modelRd = 1'b0;
        expectFill("t6_restart_comma");
        expectFill("t6_queue_cleared");
        setEnable(1'b0);
        waitIdle("t6_idle");

        // Randomized bursts against the reference encoder
        for (int r = 0; r < 4; r++) begin
            doReset();
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) begin
                bytes[i] = 8'($urandom_range(0, 255));
                writeByte(bytes[i]);
            end
            setEnable(1'b1);
            expectFill("rnd_comma");
            for (int i = 0; i < n; i++) expectByte("rnd_data", bytes[i]);
            expectFill("rnd_fill");
            setEnable(1'b0);
            waitIdle("rnd_idle");
        end

        check("bit_hold_glitches", 32'(glitches), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no completion expected finish before 5 ms");
        $fatal(1, "watchdog expired");
    end
endmodule
